// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out serializer.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Number of sout cycles one accepted word occupies.
    function automatic int frame_len(input int width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit position counter for the serializer; counts 0..WIDTH-1 and flags the LSB.
module piso_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] count;

    // Clear on every reload; otherwise advance while a data bit is on sout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// MSB-first parallel-in serial-out transmitter with valid/ready intake.
// Optional even-parity trailer bit is compiled in with PISO_PARITY_EN.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             busy
);
    import piso_pkg::*;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic             last;
    logic             final_bit;
    logic             accept;

`ifdef PISO_PARITY_EN
    logic parity_reg;
    assign final_bit = (state == PARITY);
`else
    assign final_bit = (state == SHIFT) && last;
`endif

    // Ready while idle and on the frame's final bit so words can stream gap-free.
    assign din_ready = (state == IDLE) || final_bit;
    assign accept    = din_valid && din_ready;

    piso_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable ((state == SHIFT) && !last),
        .last   (last)
    );

`ifdef PISO_PARITY_EN
    // Parity is taken from the captured word so the shifting data is not needed later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_reg <= 1'b0;
        end else if (accept) begin
            parity_reg <= ^din;
        end
    end
`endif

    // Frame FSM: capture, shift out, optional parity trailer, registered outputs.
    // sout always mirrors the MSB of shift_reg while a data bit is being sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sof        <= 1'b0;
            busy       <= 1'b0;
        end else if (accept) begin
            state      <= SHIFT;
            shift_reg  <= din;
            sout       <= din[WIDTH-1];
            sout_valid <= 1'b1;
            sof        <= 1'b1;
            busy       <= 1'b1;
        end else begin
            case (state)
                SHIFT: begin
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    sof       <= 1'b0;
                    if (last) begin
`ifdef PISO_PARITY_EN
                        state <= PARITY;
                        sout  <= parity_reg;
`else
                        state      <= IDLE;
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        busy       <= 1'b0;
`endif
                    end else begin
                        sout <= shift_reg[WIDTH-2];
                    end
                end
                PARITY: begin
                    state      <= IDLE;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    sof        <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    sof        <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (WIDTH=8); honours PISO_PARITY_EN.
module tb_piso_serializer;
    import piso_pkg::*;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = frame_len(W, PAR);

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         sout;
    logic         sout_valid;
    logic         sof;
    logic         busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic b;
        logic s;
    } exp_t;

    exp_t q[$];

    piso_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sof        (sof),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every valid bit must match the next expected bit and sof flag.
    always @(negedge clk) begin
        if (!rst && sout_valid) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_bit: sout=%0b with nothing expected at %0t", sout, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (sout !== e.b || sof !== e.s || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL bit_stream: got sout=%0b sof=%0b busy=%0b, want sout=%0b sof=%0b busy=1 at %0t",
                             sout, sof, busy, e.b, e.s, $time);
                end
            end
        end else if (!rst) begin
            total++;
            if (sout !== 1'b0 || sof !== 1'b0) begin
                bad++;
                $display("FAIL idle_outputs: got sout=%0b sof=%0b, want 0 0 at %0t", sout, sof, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic push_word(input logic [W-1:0] w);
        exp_t e;
        for (int i = W - 1; i >= 0; i--) begin
            e.b = w[i];
            e.s = (i == W - 1);
            q.push_back(e);
        end
        if (PAR) begin
            e.b = ^w;
            e.s = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic check_idle(input string name);
        total++;
        if (sout_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1 || sout !== 1'b0) begin
            bad++;
            $display("FAIL %s: got sout_valid=%0b busy=%0b din_ready=%0b sout=%0b, want 0 0 1 0",
                     name, sout_valid, busy, din_ready, sout);
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d expected bits never appeared", name, q.size());
        end
        q.delete();
    endtask

    // Frame-long window after an accept: busy/valid high, din_ready only on the final bit.
    task automatic run_frame(input string name);
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b1 || sout_valid !== 1'b1 || din_ready !== (k == FL - 1)) begin
                bad++;
                $display("FAIL %s_frame: bit %0d got busy=%0b sout_valid=%0b din_ready=%0b, want 1 1 %0b",
                         name, k, busy, sout_valid, din_ready, (k == FL - 1));
            end
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (sout !== 1'b0 || sout_valid !== 1'b0 || sof !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_values: got sout=%0b sout_valid=%0b sof=%0b busy=%0b din_ready=%0b, want 0 0 0 0 1",
                     sout, sout_valid, sof, busy, din_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("after_reset");
    endtask

    task automatic test_single(input logic [W-1:0] w, input string name);
        @(negedge clk);
        check_idle({name, "_pre"});
        din       = w;
        din_valid = 1'b1;
        push_word(w);
        @(posedge clk);
        #1 din_valid = 1'b0;
        run_frame(name);
        @(negedge clk);
        check_idle({name, "_post"});
        check_drained(name);
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        din       = 8'hF0;
        din_valid = 1'b1;
        push_word(8'hF0);
        push_word(8'h0F);
        @(posedge clk);
        #1 din = 8'h0F;
        for (int i = 0; i < 2 * FL; i++) begin
            @(negedge clk);
            total++;
            if (sout_valid !== 1'b1 || din_ready !== (i == FL - 1 || i == 2 * FL - 1)) begin
                bad++;
                $display("FAIL b2b_stream: slot %0d got sout_valid=%0b din_ready=%0b, want 1 %0b",
                         i, sout_valid, din_ready, (i == FL - 1 || i == 2 * FL - 1));
            end
            if (i == FL - 1) begin
                @(posedge clk);
                #1 din_valid = 1'b0;
            end
        end
        @(negedge clk);
        check_idle("b2b_post");
        check_drained("b2b");
    endtask

    task automatic test_stall;
        @(negedge clk);
        din       = 8'h3C;
        din_valid = 1'b1;
        push_word(8'h3C);
        @(posedge clk);
        #1 din = 8'hFF;
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            total++;
            if (din_ready !== (k == FL - 1) || busy !== 1'b1) begin
                bad++;
                $display("FAIL stall_ready: bit %0d got din_ready=%0b busy=%0b, want %0b 1",
                         k, din_ready, busy, (k == FL - 1));
            end
            if (k == 3) din_valid = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            check_idle("stall_post");
        end
        check_drained("stall");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        din       = 8'hFF;
        din_valid = 1'b1;
        push_word(8'hFF);
        @(posedge clk);
        #1 din_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (sout !== 1'b0 || sout_valid !== 1'b0 || sof !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_async: got sout=%0b sout_valid=%0b sof=%0b busy=%0b, want 0 0 0 0",
                     sout, sout_valid, sof, busy);
        end
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset_mid_release");
        test_single(8'h81, "after_reset_mid");
    endtask

    task automatic test_rst_handshake;
        @(negedge clk);
        rst       = 1'b1;
        din       = 8'h5A;
        din_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (sout_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_hs_no_accept: got sout_valid=%0b busy=%0b, want 0 0", sout_valid, busy);
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        push_word(8'h5A);
        @(posedge clk);
        #1 din_valid = 1'b0;
        run_frame("rst_hs");
        @(negedge clk);
        check_idle("rst_hs_post");
        check_drained("rst_hs");
    endtask

    initial begin
        test_reset();
        test_single(8'hA5, "single_a5");
        test_single(8'h07, "single_07");
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_rst_handshake();
        test_single(8'h80, "single_80");
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out transmitter that accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock. It sits in front of the team's serial shift-register chains and receivers, acting as the source of their din stream. Frames are marked with a start strobe and a per-bit valid. Back-to-back words stream with no idle gap.

## Interface
- WIDTH, 8: data word width; legal range 2–32.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din is presented this cycle.
- din_ready  output  1  block can accept a word this cycle; combinational from state.
- sout  output  1  serial data bit, registered.
- sout_valid  output  1  sout carries a frame bit this cycle, registered.
- sof  output  1  high on the first (MSB) bit of each frame, registered.
- busy  output  1  a frame is in progress, registered.

## Operation
- Reset values: sout=0, sout_valid=0, sof=0, busy=0, state=IDLE, shift register=0, bit counter=0.
- A word is accepted on a rising edge where din_valid && din_ready && !rst. din is captured into the shift register.
- States:
  - IDLE: din_ready=1. On accept, go to SHIFT.
  - SHIFT: emits shift_reg[WIDTH-1] each cycle, then shifts left with zero fill. The bit counter runs 0..WIDTH-1.
  - PARITY: exists only with parity compiled in.
- din_ready is 1 in IDLE, and also 1 in the cycle where the frame's final bit is on sout: the last data bit with no parity, or the parity bit with parity. This gives back-to-back streaming.
- Transition at the end of the final bit:
  - accept this edge: reload, stay in/return to SHIFT, counter=0.
  - no accept: go to IDLE; sout_valid and busy drop to 0, and sout returns to 0.
- din_valid without din_ready is ignored; din is not held internally.
- Bit counter width is clog2(WIDTH); it wraps to 0 only on reload.
- Reset asserted mid-frame: the frame is abandoned and outputs clear asynchronously. There is no partial-frame completion after deassertion.

## Timing
- Latency: a word accepted at edge N puts its MSB on sout during cycle N+1, with sof=1, sout_valid=1, busy=1.
- Frame length is WIDTH cycles (WIDTH+1 with parity). The LSB appears in cycle N+WIDTH.
- Back-to-back: the next frame's MSB is in the cycle immediately after the previous final bit, with sof=1 again and zero idle cycles.
- Throughput is one word per WIDTH cycles (WIDTH+1 with parity).
- sof is high for exactly one cycle per frame.

## Configuration
- Macro: PISO_PARITY_EN.
- Defined:
  - After the LSB, one extra cycle in state PARITY emits the even-parity bit (XOR of all captured data bits) with sout_valid=1 and sof=0.
  - din_ready asserts during the parity cycle instead of the LSB cycle.
  - The parity bit is computed at capture time and stored in a 1-bit register.
- Undefined: there is no PARITY state and no parity register, and the frame is exactly WIDTH bits.

## Structure
- Package piso_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - a function returning frame length for a given WIDTH and parity setting.
- Sub-module piso_bit_counter:
  - a clog2(WIDTH)-bit counter with inputs clear and enable;
  - a terminal-count output `last`, asserted at WIDTH-1.
- Top level holds the FSM, shift register, parity register and output registers.

## Test plan
- Reset then single word, WIDTH=8: accept 0xA5 at edge N, din_valid then dropped. Expect sout 1,0,1,0,0,1,0,1 over cycles N+1..N+8, sof only at N+1, sout_valid/busy high for 8 cycles, then all 0 and din_ready=1.
- Back-to-back: hold din_valid=1 with 0xF0 then 0x0F. Expect 16 contiguous valid bits 1111000000001111, sof at bit 0 and bit 8, no gap.
- Stall: din_valid=1 while busy and not on the final bit. Expect din_ready=0 and the word ignored; the current frame is unaffected.
- Reset mid-frame: assert rst after 3 bits of 0xFF. Expect sout/sout_valid/sof/busy=0 immediately. After deassertion, din_ready=1, and a new 0x81 serializes as 10000001.
- PISO_PARITY_EN defined: 0xA5 gives 9 bits, with parity bit 0. 0x07 gives 00000111 then 1. din_ready high only on the parity cycle.
- Handshake edge: din_valid rising in the same cycle rst falls. Expect no accept while rst is high, and acceptance on the first edge with rst low.
